// File: rtl/vga_syncdet_pkg.sv
// Shared types and helpers for the VGA sync timing detector.
// Detector state encoding is exported here so status logic can decode it.
package vga_syncdet_pkg;

  localparam int unsigned CntW = 10;
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntOne = 10'd1;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StMeasure = 2'd1,
    StLocked  = 2'd2
  } state_e;

  // Measurement counters stick at full scale instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

endpackage

// File: rtl/vga_syncdet_sync_meas.sv
// Per-axis sync measurer: counts ticks between start events (period) and
// ticks while the sync is active (width). Both counters saturate.
module vga_syncdet_sync_meas
  import vga_syncdet_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tick_i,
  input  logic            start_i,
  input  logic            active_i,
  output logic [CntW-1:0] period_cnt_o,
  output logic [CntW-1:0] period_o,
  output logic [CntW-1:0] wid_cnt_o
);

  logic [CntW-1:0] per_q, per_d;
  logic [CntW-1:0] len_q, len_d;
  logic [CntW-1:0] wid_q, wid_d;

  always_comb begin
    per_d = per_q;
    len_d = len_q;
    wid_d = wid_q;
    if (start_i) begin
      len_d = per_q;
      per_d = CntOne;
    end else if (tick_i) begin
      per_d = sat_inc(per_q);
    end
    if (start_i) begin
      wid_d = CntOne;
    end else if (tick_i && active_i) begin
      wid_d = sat_inc(wid_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      per_q <= '0;
      len_q <= '0;
      wid_q <= '0;
    end else begin
      per_q <= per_d;
      len_q <= len_d;
      wid_q <= wid_d;
    end
  end

  assign period_cnt_o = per_q;
  assign period_o     = len_q;
  assign wid_cnt_o    = wid_q;

endmodule

// File: rtl/vga_syncdet.sv
// VGA sync timing detector: verifies HS/VS timing over two frames, then
// regenerates HCNT/VCNT cycle-aligned with the transmitter's counters.
module vga_syncdet
  import vga_syncdet_pkg::*;
#(
  parameter int unsigned HPeriod = 800,
  parameter int unsigned HFront  = 16,
  parameter int unsigned HWidth  = 96,
  parameter int unsigned VPeriod = 525,
  parameter int unsigned VFront  = 10,
  parameter int unsigned VWidth  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hs_i,
  input  logic       vs_i,
  output logic       locked_o,
  output logic [9:0] hcnt_o,
  output logic [9:0] vcnt_o,
  output logic [9:0] hlen_o,
  output logic [9:0] vlen_o,
  output logic       err_o
);

  localparam logic [CntW-1:0] HPeriodW = CntW'(HPeriod);
  localparam logic [CntW-1:0] HWidthW  = CntW'(HWidth);
  localparam logic [CntW-1:0] HLastW   = CntW'(HPeriod - 1);
  localparam logic [CntW-1:0] HStartW  = (HFront + 1 == HPeriod) ? '0 : CntW'(HFront + 1);
  localparam logic [CntW-1:0] VPeriodW = CntW'(VPeriod);
  localparam logic [CntW-1:0] VWidthW  = CntW'(VWidth);
  localparam logic [CntW-1:0] VLastW   = CntW'(VPeriod - 1);
  localparam logic [CntW-1:0] VFrontW  = CntW'(VFront);

  logic hs_q, vs_q;
  logic hfall, vfall;
  logic [CntW-1:0] hlen_cnt, hw_cnt, vline, vw_cnt;
  logic good_line, good_frame, hsat;

  state_e state_q, state_d;
  logic first_q, first_d;
  logic err_q, err_d;
  logic [CntW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;

  assign hfall = hs_q & ~hs_i;
  assign vfall = vs_q & ~vs_i;

  vga_syncdet_sync_meas u_hmeas (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tick_i       (1'b1),
    .start_i      (hfall),
    .active_i     (~hs_i),
    .period_cnt_o (hlen_cnt),
    .period_o     (hlen_o),
    .wid_cnt_o    (hw_cnt)
  );

  vga_syncdet_sync_meas u_vmeas (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tick_i       (hfall),
    .start_i      (vfall),
    .active_i     (~vs_i),
    .period_cnt_o (vline),
    .period_o     (vlen_o),
    .wid_cnt_o    (vw_cnt)
  );

  // hw_cnt only moves while HS is low, so at hfall it still holds the last width.
  assign good_line  = (hlen_cnt == HPeriodW) && (hw_cnt == HWidthW);
  assign good_frame = (vline == VPeriodW) && (vw_cnt == VWidthW) && hfall;
  assign hsat       = (hlen_cnt == CntMax);

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    err_d   = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (vfall) begin
          state_d = StMeasure;
          first_d = 1'b1;
        end
      end
      StMeasure: begin
        if (hfall) first_d = 1'b0;
        if (hsat || (hfall && !first_q && !good_line)) begin
          state_d = StSearch;
        end else if (vfall && good_frame) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (hsat || (hfall && !good_line) || (vfall && !good_frame) || (vline > VPeriodW)) begin
          state_d = StSearch;
          err_d   = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_comb begin
    hcnt_d = '0;
    vcnt_d = '0;
    if (state_d == StLocked) begin
      if (state_q != StLocked) begin
        // The locking hfall sits at HCNT==HFRONT on the transmitter side.
        hcnt_d = HStartW;
        vcnt_d = VFrontW;
      end else if (hcnt_q == HLastW) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VLastW) ? '0 : vcnt_q + CntOne;
      end else begin
        hcnt_d = hcnt_q + CntOne;
        vcnt_d = vcnt_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      state_q <= StSearch;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      hs_q    <= hs_i;
      vs_q    <= vs_i;
      state_q <= state_d;
      first_q <= first_d;
      err_q   <= err_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign locked_o = (state_q == StLocked);
  assign err_o    = err_q;
  assign hcnt_o   = hcnt_q;
  assign vcnt_o   = vcnt_q;

endmodule

// File: tb/tb_vga_syncdet.sv
// Directed bench for vga_syncdet: a small-raster sync source drives the DUT,
// each scenario task checks its own hand-computed expectations.
module tb_vga_syncdet;

  localparam int HP = 40;
  localparam int HF = 4;
  localparam int HW = 6;
  localparam int VP = 20;
  localparam int VF = 3;
  localparam int VW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs = 1'b1;
  logic vs = 1'b1;
  logic locked, err;
  logic [9:0] hcnt, vcnt, hlen, vlen;

  int n_cmp = 0;
  int n_bad = 0;

  // Source model state
  int gen_h = 0;
  int gen_v = 0;
  int hper = HP;
  int kill_v = -1;
  bit stuck = 1'b0;
  bit vs_late = 1'b0;
  bit vs_low_d = 1'b0;

  vga_syncdet #(
    .HPeriod (HP),
    .HFront  (HF),
    .HWidth  (HW),
    .VPeriod (VP),
    .VFront  (VF),
    .VWidth  (VW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .hs_i     (hs),
    .vs_i     (vs),
    .locked_o (locked),
    .hcnt_o   (hcnt),
    .vcnt_o   (vcnt),
    .hlen_o   (hlen),
    .vlen_o   (vlen),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  function automatic bit vl_of(input int h, input int v);
    return (v == VF && h >= HF) || (v > VF && v < VF + VW) || (v == VF + VW && h < HF);
  endfunction

  task automatic drive();
    bit hl;
    hl = (gen_h >= HF) && (gen_h < HF + HW);
    hs = stuck ? 1'b0 : (gen_v == kill_v) ? 1'b1 : !hl;
    vs = stuck ? 1'b1 : vs_late ? !vs_low_d : !vl_of(gen_h, gen_v);
  endtask

  // One pixel clock: the DUT samples the current cycle, then the source advances.
  task automatic tick();
    @(posedge clk);
    #1;
    vs_low_d = vl_of(gen_h, gen_v);
    if (gen_h >= hper - 1) begin
      gen_h = 0;
      gen_v = (gen_v == VP - 1) ? 0 : gen_v + 1;
    end else begin
      gen_h++;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gen_h = 0;
    gen_v = 0;
    hper = HP;
    kill_v = -1;
    stuck = 1'b0;
    vs_late = 1'b0;
    vs_low_d = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic run_until(input int h, input int v, input int budget);
    int n;
    n = 0;
    while (!(gen_h == h && gen_v == v) && n < budget) begin
      tick();
      n++;
    end
    if (!(gen_h == h && gen_v == v)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_until: reached h=%0d v=%0d, required h=%0d v=%0d", gen_h, gen_v, h, v);
    end
  endtask

  task automatic wait_lock(input int budget, output int n);
    n = 0;
    while (!locked && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({locked, err} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags: got locked=%b err=%b, required 0 0", locked, err);
    end
    n_cmp++;
    if ({hcnt, vcnt} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got hcnt=%0d vcnt=%0d, required 0 0", hcnt, vcnt);
    end
    n_cmp++;
    if ({hlen, vlen} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset_len: got hlen=%0d vlen=%0d, required 0 0", hlen, vlen);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_lock();
    int n;
    int bad;
    do_reset();
    wait_lock(3000, n);
    n_cmp++;
    if (n !== 925) begin
      n_bad++;
      $display("FAIL lock_time: got %0d cycles, required 925", n);
    end
    n_cmp++;
    if ({hcnt, vcnt} !== {10'(gen_h), 10'(gen_v)} || gen_h != HF + 1 || gen_v != VF) begin
      n_bad++;
      $display("FAIL lock_align: got hcnt=%0d vcnt=%0d, required %0d %0d", hcnt, vcnt, HF + 1, VF);
    end
    n_cmp++;
    if ({hlen, vlen} !== {10'd40, 10'd20}) begin
      n_bad++;
      $display("FAIL lock_len: got hlen=%0d vlen=%0d, required 40 20", hlen, vlen);
    end
    for (int f = 0; f < 3; f++) begin
      bad = 0;
      repeat (HP * VP) begin
        tick();
        if (locked !== 1'b1 || err !== 1'b0 || hcnt !== 10'(gen_h) || vcnt !== 10'(gen_v)) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL align_frame%0d: got %0d misaligned cycles, required 0", f, bad);
      end
    end
  endtask

  task automatic test_missing_hs();
    int errs;
    int pos;
    int n;
    errs = 0;
    pos = -1;
    kill_v = 8;
    n = 0;
    while (!(gen_v == 9 && gen_h == 10) && n < 1000) begin
      tick();
      n++;
      if (err === 1'b1) begin
        errs++;
        pos = gen_v * HP + gen_h;
      end
    end
    kill_v = -1;
    drive();
    n_cmp++;
    if (errs != 1) begin
      n_bad++;
      $display("FAIL kill_err_count: got %0d pulses, required 1", errs);
    end
    n_cmp++;
    if (pos != 365) begin
      n_bad++;
      $display("FAIL kill_err_pos: got %0d, required 365", pos);
    end
    n_cmp++;
    if ({locked, hcnt, vcnt} !== 21'd0) begin
      n_bad++;
      $display("FAIL kill_drop: got locked=%b hcnt=%0d vcnt=%0d, required 0 0 0", locked, hcnt, vcnt);
    end
    wait_lock(3000, n);
    n_cmp++;
    if (n !== 1355) begin
      n_bad++;
      $display("FAIL kill_relock: got %0d cycles, required 1355", n);
    end
    n_cmp++;
    if ({hcnt, vcnt} !== {10'(gen_h), 10'(gen_v)}) begin
      n_bad++;
      $display("FAIL kill_realign: got hcnt=%0d vcnt=%0d, required %0d %0d", hcnt, vcnt, gen_h, gen_v);
    end
  endtask

  task automatic test_long_line();
    int locks;
    int errs;
    do_reset();
    hper = HP + 1;
    locks = 0;
    errs = 0;
    repeat (4000) begin
      tick();
      if (locked !== 1'b0) locks++;
      if (err !== 1'b0) errs++;
    end
    n_cmp++;
    if (locks != 0 || errs != 0) begin
      n_bad++;
      $display("FAIL long_nolock: got %0d locked and %0d err cycles, required 0 0", locks, errs);
    end
    n_cmp++;
    if (hlen !== 10'd41) begin
      n_bad++;
      $display("FAIL long_hlen: got %0d, required 41", hlen);
    end
    n_cmp++;
    if (vlen !== 10'd20) begin
      n_bad++;
      $display("FAIL long_vlen: got %0d, required 20", vlen);
    end
  endtask

  task automatic test_vs_late();
    int locks;
    do_reset();
    vs_late = 1'b1;
    drive();
    run_until(HF + 2, VF, 1000);
    n_cmp++;
    if (vlen !== 10'd4) begin
      n_bad++;
      $display("FAIL late_vlen0: got %0d, required 4", vlen);
    end
    locks = 0;
    repeat (HP * VP) begin
      tick();
      if (locked !== 1'b0) locks++;
    end
    n_cmp++;
    if (vlen !== 10'd21) begin
      n_bad++;
      $display("FAIL late_vlen1: got %0d, required 21", vlen);
    end
    n_cmp++;
    if (locks != 0) begin
      n_bad++;
      $display("FAIL late_nolock: got %0d locked cycles, required 0", locks);
    end
  endtask

  task automatic test_stuck_low();
    int n;
    do_reset();
    wait_lock(3000, n);
    run_until(HF + 1, 8, 2000);
    stuck = 1'b1;
    drive();
    n = 0;
    while (err !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 1023) begin
      n_bad++;
      $display("FAIL stuck_sat_time: got %0d cycles, required 1023", n);
    end
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++;
      $display("FAIL stuck_drop: got locked=%b, required 0", locked);
    end
    repeat (300) tick();
    n_cmp++;
    if ($isunknown({locked, err, hcnt, vcnt, hlen, vlen}) || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL stuck_clean: got locked=%b err=%b hcnt=%h vcnt=%h, required 0 0 000 000",
               locked, err, hcnt, vcnt);
    end
    n = 0;
    while (gen_h != 20 && n < 100) begin
      tick();
      n++;
    end
    stuck = 1'b0;
    drive();
    n = 0;
    while (gen_h != HF + 1 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (hlen !== 10'd1023) begin
      n_bad++;
      $display("FAIL stuck_hlen: got %0d, required 1023", hlen);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    wait_lock(3000, n);
    run_until(0, 10, 2000);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({locked, err, hcnt, vcnt, hlen, vlen} !== 42'd0) begin
        n_bad++;
        $display("FAIL midrst_zero%0d: got locked=%b err=%b hcnt=%0d vcnt=%0d hlen=%0d vlen=%0d, required all 0",
                 i, locked, err, hcnt, vcnt, hlen, vlen);
      end
    end
    rst = 1'b0;
    wait_lock(3000, n);
    n_cmp++;
    if (n !== 1322) begin
      n_bad++;
      $display("FAIL midrst_relock: got %0d cycles, required 1322", n);
    end
    n_cmp++;
    if ({hcnt, vcnt} !== {10'(gen_h), 10'(gen_v)}) begin
      n_bad++;
      $display("FAIL midrst_align: got hcnt=%0d vcnt=%0d, required %0d %0d", hcnt, vcnt, gen_h, gen_v);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_missing_hs();
    test_long_line();
    test_vs_late();
    test_stuck_low();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/vga_syncdet.md
# vga_syncdet

VGA sync timing detector: the receive-side counterpart of the team's VGA sync generator. It samples active-low HS/VS in the pixel-clock domain and measures line length, HS width, frame length and VS width against the `vga_param.vh` constants. After two consecutive conforming frames it declares lock and regenerates HCNT/VCNT cycle-aligned with the transmitter's counters. It sits on the capture/loopback side of the video path and drives pixel-addressing logic downstream.

## Interface
Parameters (defaults are 640x480, 60 Hz):
- HPERIOD, 800, pixels per line
- HFRONT, 16, HCNT value at which HS goes low
- HWIDTH, 96, HS low width in pixels
- VPERIOD, 525, lines per frame
- VFRONT, 10, line on which VS goes low
- VWIDTH, 2, VS low width in lines

Ports:
- CLK  in  1  pixel clock, same frequency and phase as the transmitter's PCK
- RST  in  1  reset; **asynchronous, active-high**
- HS_IN  in  1  horizontal sync, active low
- VS_IN  in  1  vertical sync, active low
- LOCKED  out  1  timing verified; HCNT/VCNT are valid
- HCNT  out  10  recovered horizontal count
- VCNT  out  10  recovered vertical count
- HLEN  out  10  last measured line length in cycles
- VLEN  out  10  last measured frame length in lines
- ERR  out  1  one-cycle pulse when LOCKED is lost

## Operation
- hs_q and vs_q register the previous HS_IN/VS_IN values; both reset to 1.
- Edge terms:
  - hfall = hs_q & ~HS_IN
  - hrise = ~hs_q & HS_IN
  - vfall = vs_q & ~VS_IN
- Line length (hlen_cnt):
  - +1 per cycle, saturating at 1023.
  - On hfall: HLEN <= hlen_cnt, then hlen_cnt <= 1.
- HS width (hw_cnt):
  - Loads 1 on hfall; +1 per cycle while HS_IN=0.
  - On hrise: hwid <= hw_cnt.
- Line check, evaluated at each hfall: good_line = (hlen_cnt==HPERIOD && hwid==HWIDTH).
- Line count (vline): +1 on each hfall. On vfall: VLEN <= vline, then vline <= 1.
- VS width (vw_cnt): loads 1 on vfall; +1 on each later hfall where VS_IN=0.
- Frame check, evaluated at vfall: good_frame = (vline==VPERIOD && vw_cnt==VWIDTH && hfall).
- A vfall without a coincident hfall is a bad frame.
- State machine (reset state SEARCH):
  - SEARCH: on vfall -> MEASURE.
  - MEASURE:
    - Bad line at any hfall except the first after entry -> SEARCH.
    - hlen_cnt==1023 -> SEARCH.
    - At vfall: good_frame -> LOCKED, otherwise stay in MEASURE and restart the frame.
  - LOCKED:
    - Bad line, bad frame, or vline exceeding VPERIOD -> SEARCH, with ERR=1 for one cycle.
    - hlen_cnt==1023 -> SEARCH, with ERR=1 for one cycle.
- Recovered counters:
  - On the edge entering LOCKED: HCNT <= HFRONT+1, VCNT <= VFRONT.
  - While in LOCKED: HCNT wraps HPERIOD-1 -> 0; VCNT advances on HCNT wrap and wraps VPERIOD-1 -> 0.
  - Outside LOCKED: HCNT = VCNT = 0.
- All arithmetic is 10-bit unsigned. Measurement counters saturate; they never wrap.

## Timing
- Reset values:
  - LOCKED=0, ERR=0, HCNT=0, VCNT=0, HLEN=0, VLEN=0
  - all internal counters 0, hs_q=vs_q=1, state=SEARCH
- Alignment: when fed directly by the sync generator on the same clock, HCNT/VCNT equal the generator's counters in every cycle while LOCKED=1 (zero lag).
- LOCKED rises on the clock edge that samples the second conforming vfall after SEARCH.
- LOCKED falls and ERR pulses on the edge that samples the violation. HCNT/VCNT read 0 in the following cycle.
- Simultaneous hfall and vfall is the normal case: the line check and frame check are both evaluated in that cycle.
- RST asserted mid-frame clears everything immediately (asynchronous); detection restarts from SEARCH.

## Structure
- HPERIOD/HFRONT/HWIDTH/VPERIOD/VFRONT/VWIDTH stay in the shared `vga_param.vh`; the defaults above mirror it.
- State encoding (SEARCH=2'd0, MEASURE=2'd1, LOCKED=2'd2) goes into `vga_param.vh` for reuse by status logic.
- One natural sub-module: `sync_meas`, a per-axis period/width measurer instantiated for H (counting cycles) and V (counting hfall events).

## Test plan
- Sync generator drives HS/VS, default parameters, RST released -> LOCKED=1 after the second VS fall (about 2×420000 cycles); HLEN=800, VLEN=525; HCNT/VCNT match the generator every cycle for 3 frames.
- While locked, hold HS_IN high for one line -> ERR pulses once, LOCKED=0, HCNT=0; relocks two frames later.
- Source with HPERIOD=801 -> LOCKED never rises; HLEN=801.
- Stimulus with the VS fall one cycle after the HS fall -> no lock; VLEN updates each frame.
- HS_IN stuck low -> hlen_cnt saturates at 1023; state returns to SEARCH; no X on any output.
- RST pulsed for 3 cycles mid-frame while locked -> all outputs read 0 during reset; relock on the second conforming frame.
